// File: rtl/neural_net_axi_slave.sv
// neural_net_axi_slave: AXI4-Lite responder exposing four 32-bit control/status
// registers to the neural-net accelerator core.
//
// Ports:
//   ACLK, ARESET          - single clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W*  - write address / data channels (accepted independently)
//   S_AXI_B*              - write response channel (always OKAY)
//   S_AXI_AR* / S_AXI_R*  - read address / data channels (always OKAY)
//   regs_out              - {reg3, reg2, reg1, reg0} live register contents
//   reg_wr_pulse          - one-cycle pulse per register following its commit
module neural_net_axi_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   regs_out,
  output logic [3:0]                        reg_wr_pulse
);

  localparam int unsigned DW        = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NUM_BYTES = DW / 8;
  localparam int unsigned NUM_REGS  = 4;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  logic [1:0]                 w_state, w_state_nxt;
  logic                       r_state, r_state_nxt;

  logic [NUM_REGS-1:0][DW-1:0] regs_q;
  logic [1:0]                 aw_idx_q;
  logic [DW-1:0]              wdata_q;
  logic [NUM_BYTES-1:0]       wstrb_q;

  logic                       aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
  logic                       commit_c, latch_aw_c, latch_w_c;
  logic [1:0]                 commit_idx_c;
  logic [DW-1:0]              commit_data_c;
  logic [NUM_BYTES-1:0]       commit_strb_c;

  // Protection bits and the byte-offset address bits carry no meaning here.
  logic unused_c;
  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign regs_out    = regs_q;

  // Handshakes use only registered READY/VALID outputs, so no comb path to outputs.
  assign aw_hs_c = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs_c  = S_AXI_WVALID  & S_AXI_WREADY;
  assign b_hs_c  = S_AXI_BVALID  & S_AXI_BREADY;
  assign ar_hs_c = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs_c  = S_AXI_RVALID  & S_AXI_RREADY;

  // State registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // Write next-state and commit selection; the later of AW/W commits.
  always_comb begin
    w_state_nxt   = w_state;
    commit_c      = 1'b0;
    latch_aw_c    = 1'b0;
    latch_w_c     = 1'b0;
    commit_idx_c  = aw_idx_q;
    commit_data_c = wdata_q;
    commit_strb_c = wstrb_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          commit_c      = 1'b1;
          commit_idx_c  = S_AXI_AWADDR[3:2];
          commit_data_c = S_AXI_WDATA;
          commit_strb_c = S_AXI_WSTRB;
          w_state_nxt   = W_RESP;
        end else if (aw_hs_c) begin
          latch_aw_c  = 1'b1;
          w_state_nxt = W_ADDR;
        end else if (w_hs_c) begin
          latch_w_c   = 1'b1;
          w_state_nxt = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_hs_c) begin
          commit_c      = 1'b1;
          commit_data_c = S_AXI_WDATA;
          commit_strb_c = S_AXI_WSTRB;
          w_state_nxt   = W_RESP;
        end
      end
      W_DATA: begin
        if (aw_hs_c) begin
          commit_c     = 1'b1;
          commit_idx_c = S_AXI_AWADDR[3:2];
          w_state_nxt  = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs_c) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read next-state.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs_c) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs_c)  r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Registered channel outputs decoded from the next state.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b1;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b1;
      S_AXI_RVALID  <= 1'b0;
      reg_wr_pulse  <= 4'b0000;
    end else begin
      S_AXI_AWREADY <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_DATA);
      S_AXI_WREADY  <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_ADDR);
      S_AXI_BVALID  <= (w_state_nxt == W_RESP);
      S_AXI_ARREADY <= (r_state_nxt == R_IDLE);
      S_AXI_RVALID  <= (r_state_nxt == R_DATA);
      reg_wr_pulse  <= commit_c ? (4'b0001 << commit_idx_c) : 4'b0000;
    end
  end

  // Half-transaction latches for split AW/W arrival.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_idx_q <= 2'b00;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (latch_aw_c) aw_idx_q <= S_AXI_AWADDR[3:2];
      if (latch_w_c) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register file with byte-enable merge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_q <= '0;
    end else if (commit_c) begin
      for (int unsigned n = 0; n < NUM_BYTES; n++) begin
        if (commit_strb_c[n]) regs_q[commit_idx_c][n*8 +: 8] <= commit_data_c[n*8 +: 8];
      end
    end
  end

  // Read data captured at the AR handshake; pre-write value on a same-edge commit.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_RDATA <= '0;
    end else if (ar_hs_c) begin
      S_AXI_RDATA <= regs_q[S_AXI_ARADDR[3:2]];
    end
  end

endmodule

// File: doc/neural_net_axi_slave.md
# neural_net_axi_slave

AXI4-Lite responder that fronts the neural-net accelerator's control/status space with four 32-bit read/write registers. The system-level AXI4-Lite master writes and reads the registers. The block presents the register contents and per-register write strobes to the accelerator core. AW and W channels are accepted independently and in either order. B and R channels honour master back-pressure.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: address width; bits [3:2] select the register, bits [1:0] are ignored.
- ACLK  in  1  single clock; all logic is on its rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- regs_out  out  128  {reg3, reg2, reg1, reg0}; the live register values.
- reg_wr_pulse  out  4  one-cycle pulse per register, asserted after that register is written.

## Operation
- Reset values: all registers 0, regs_out 0, reg_wr_pulse 0, AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, RDATA 0, BRESP/RRESP 0.
- The write FSM has four states:
  - W_IDLE: AWREADY=1, WREADY=1.
    - AW and W both handshake in the same cycle: commit, go to W_RESP.
    - Only AW handshakes: latch the address, go to W_ADDR.
    - Only W handshakes: latch data and strobe, go to W_DATA.
  - W_ADDR: AWREADY=0, WREADY=1. On the W handshake, commit using the latched address, go to W_RESP.
  - W_DATA: AWREADY=1, WREADY=0. On the AW handshake, commit using the latched data, go to W_RESP.
  - W_RESP: AWREADY=WREADY=0, BVALID=1. On BVALID&BREADY, go to W_IDLE.
- Commit rules:
  - Byte n of reg[addr[3:2]] is updated iff WSTRB[n]=1.
  - WSTRB=0 still completes the transaction with an OKAY response and a pulse, but leaves the data unchanged.
- The read FSM has two states:
  - R_IDLE: ARREADY=1. On the AR handshake, load RDATA with reg[ARADDR[3:2]], go to R_DATA.
  - R_DATA: ARREADY=0, RVALID=1. RDATA is held stable until RREADY. On RVALID&RREADY, go to R_IDLE.
- The read and write FSMs are fully independent.
- A read captured on the same edge as a write commit to the same register returns the pre-write value.
- ARESET asserted mid-transaction aborts all state at that edge and restores the reset values. The partial write is discarded and any pending B or R is dropped.

## Timing
- Write commit happens on the edge of the later of the AW and W handshakes. regs_out, BVALID=1 and reg_wr_pulse are all visible in the cycle following that edge.
- reg_wr_pulse is high for exactly one cycle per commit.
- With BREADY held high, BVALID lasts one cycle. AWREADY and WREADY return high in the cycle after the B handshake.
- Maximum write throughput is one write per 2 cycles.
- With RREADY held high, the read latency is RVALID one cycle after the AR handshake. ARREADY returns high the cycle after the R handshake.
- Maximum read throughput is one read per 2 cycles.
- No combinational path exists from any VALID or READY input to any READY or VALID output. All outputs are registered.

## Test plan
- Sequential write/read: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, reading each back immediately.
  - Every read returns the same word with RRESP=BRESP=00.
  - regs_out ends as {BEEF0011, DEAD0011, ABCD0001, 0101FFFF}.
- AW before W: assert AWVALID (addr 0x4) 3 cycles before WVALID (0x12345678).
  - AWREADY is low during the wait.
  - reg1 becomes 0x12345678 the cycle after the W handshake.
  - reg_wr_pulse is 4'b0010 for 1 cycle.
  - Repeat with W first: same result.
- Back-pressure:
  - Hold BREADY low for 5 cycles. BVALID stays 1 and AWREADY/WREADY stay 0 throughout; a second write is not accepted until after the B handshake.
  - Hold RREADY low for 5 cycles. RDATA stays constant.
- Byte strobes: reg2=0xDEAD0011, then write 0xFFFFFFFF with WSTRB=4'b0011 -> reg2 reads 0xDEADFFFF.
- Same-edge read/write: with reg3=0xBEEF0011, commit 0x0 to 0xC on the same edge that AR to 0xC handshakes.
  - The read returns 0xBEEF0011.
  - A subsequent read returns 0x00000000.
- Mid-transaction reset: AW is accepted, then ARESET is pulsed for 1 cycle before W arrives.
  - All outputs return to their reset values.
  - The later W alone causes no commit.
  - A full write afterwards completes normally.
